// File: rtl/college_pkg.sv
// College score types, grade thresholds and helper functions shared by the
// report-card block and its input FIFO.
package college_pkg;

    typedef logic [7:0] score_t;
    typedef logic [9:0] total_t;

    typedef enum logic [2:0] {
        GRADE_A = 3'd0,
        GRADE_B = 3'd1,
        GRADE_C = 3'd2,
        GRADE_D = 3'd3,
        GRADE_F = 3'd4
    } grade_t;

    typedef struct packed {
        score_t math;
        score_t physics;
        score_t lab;
    } score_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam score_t GRADE_A_MIN = 8'd90;
    localparam score_t GRADE_B_MIN = 8'd80;
    localparam score_t GRADE_C_MIN = 8'd70;
    localparam score_t GRADE_D_MIN = 8'd60;

    localparam score_rec_t REC_ZERO = '{math: 8'd0, physics: 8'd0, lab: 8'd0};

    // Letter grade from the floor average; thresholds are inclusive lower bounds.
    function automatic grade_t to_grade(input score_t avg);
        grade_t g;
        if (avg >= GRADE_A_MIN) begin
            g = GRADE_A;
        end else if (avg >= GRADE_B_MIN) begin
            g = GRADE_B;
        end else if (avg >= GRADE_C_MIN) begin
            g = GRADE_C;
        end else if (avg >= GRADE_D_MIN) begin
            g = GRADE_D;
        end else begin
            g = GRADE_F;
        end
        return g;
    endfunction

    // Zero-extended three-way sum; 10 bits hold the worst case 3*255 = 765.
    function automatic total_t rec_total(input score_rec_t rec);
        return {2'b00, rec.math} + {2'b00, rec.physics} + {2'b00, rec.lab};
    endfunction

    // Fail flag: any single subject below the pass minimum.
    function automatic logic rec_fail(input score_rec_t rec, input score_t pass_min);
        return (rec.math < pass_min) || (rec.physics < pass_min) || (rec.lab < pass_min);
    endfunction

endpackage

// File: rtl/college_score_fifo.sv
// DEPTH-entry FIFO of score records. Push is ignored when full and pop is
// ignored when empty, so the occupancy count can never under/overflow.
module college_score_fifo
    import college_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  score_rec_t      i_wr_data,
    output score_rec_t      o_rd_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CW-1:0]   o_count
);

    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    score_rec_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == CNT_ZERO);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: write the incoming record at the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= REC_ZERO;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy count; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_ZERO;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/college_report_card.sv
// Report-card stage: buffers score records, then per record registers the
// total, floor average, letter grade and fail flag and holds them under a
// valid/ready handshake until the consumer accepts.
// Optional feature macro: COLLEGE_REPORT_STATS_EN adds stat_count and
// stat_max_avg outputs updated on every accepted report.
module college_report_card
    import college_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PASS_MIN = 40
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_math,
    input  logic [7:0]  in_physics,
    input  logic [7:0]  in_lab,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_total,
    output logic [7:0]  out_avg,
    output logic [2:0]  out_grade,
    output logic        out_fail
`ifdef COLLEGE_REPORT_STATS_EN
    ,
    output logic [15:0] stat_count,
    output logic [7:0]  stat_max_avg
`endif
);

    localparam int     CW         = $clog2(DEPTH) + 1;
    localparam score_t PASS_MIN_S = score_t'(PASS_MIN);

    state_t          r_state;
    state_t          w_state_next;
    score_rec_t      w_in_rec;
    score_rec_t      w_head;
    score_rec_t      r_work;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic            w_push;
    logic            w_pop;
    logic            w_calc;
    logic            w_release;
    logic            r_head_avail;

    total_t          w_total;
    score_t          w_avg;
    grade_t          w_grade;
    logic            w_fail;

    logic            r_out_valid;
    total_t          r_out_total;
    score_t          r_out_avg;
    grade_t          r_out_grade;
    logic            r_out_fail;

    assign w_in_rec = '{math: in_math, physics: in_physics, lab: in_lab};
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    college_score_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_wr_data  (w_in_rec),
        .o_rd_data  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // FSM's view of FIFO occupancy: a push becomes visible one cycle after
    // it lands, and the flag drops on the pop edge so a stale "available"
    // can never trigger a second pop of the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_avail <= 1'b0;
        end else begin
            r_head_avail <= (w_count != CW'(1'b0)) && !w_pop;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_head_avail) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready && r_head_avail) begin
                    w_state_next = ST_CALC;
                end else if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM control outputs: pop the FIFO head, compute, release the report.
    always_comb begin
        w_pop     = 1'b0;
        w_calc    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = r_head_avail && !w_empty;
            end
            ST_CALC: begin
                w_calc = 1'b1;
            end
            ST_HOLD: begin
                w_release = out_ready;
                w_pop     = out_ready && r_head_avail && !w_empty;
            end
            default: begin
                w_pop     = 1'b0;
                w_calc    = 1'b0;
                w_release = 1'b0;
            end
        endcase
    end

    // Work register: holds the record being graded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work <= REC_ZERO;
        end else if (w_pop) begin
            r_work <= w_head;
        end
    end

    // Report arithmetic on the work register.
    always_comb begin
        w_total = rec_total(r_work);
        w_avg   = score_t'(w_total / 10'd3);
        w_grade = to_grade(w_avg);
        w_fail  = rec_fail(r_work, PASS_MIN_S);
    end

    // Report registers: loaded in CALC, held stable while waiting for out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_total <= 10'd0;
            r_out_avg   <= 8'd0;
            r_out_grade <= GRADE_A;
            r_out_fail  <= 1'b0;
        end else if (w_calc) begin
            r_out_valid <= 1'b1;
            r_out_total <= w_total;
            r_out_avg   <= w_avg;
            r_out_grade <= w_grade;
            r_out_fail  <= w_fail;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_total = r_out_total;
    assign out_avg   = r_out_avg;
    assign out_grade = r_out_grade;
    assign out_fail  = r_out_fail;

`ifdef COLLEGE_REPORT_STATS_EN
    logic [15:0] r_stat_count;
    score_t      r_stat_max_avg;

    // Accepted-report statistics: saturating count and running maximum average.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_count   <= 16'h0000;
            r_stat_max_avg <= 8'd0;
        end else if (r_out_valid && out_ready) begin
            if (r_stat_count != 16'hFFFF) begin
                r_stat_count <= r_stat_count + 16'h0001;
            end
            if (r_out_avg > r_stat_max_avg) begin
                r_stat_max_avg <= r_out_avg;
            end
        end
    end

    assign stat_count   = r_stat_count;
    assign stat_max_avg = r_stat_max_avg;
`endif

endmodule

// File: tb/tb_college_report_card.sv
// Directed, table-driven bench for college_report_card (DEPTH=4, PASS_MIN=40).
module tb_college_report_card;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_math;
    logic [7:0]  in_physics;
    logic [7:0]  in_lab;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_total;
    logic [7:0]  out_avg;
    logic [2:0]  out_grade;
    logic        out_fail;
`ifdef COLLEGE_REPORT_STATS_EN
    logic [15:0] stat_count;
    logic [7:0]  stat_max_avg;
`endif

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int max_avg_model = 0;

    typedef struct {
        logic [7:0] m;
        logic [7:0] p;
        logic [7:0] l;
        int         total;
        int         avg;
        int         grade;
        int         fail;
    } vec_t;

    vec_t vecs[11];
    vec_t bp[5];

    college_report_card #(
        .DEPTH        (4),
        .PASS_MIN     (40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_math      (in_math),
        .in_physics   (in_physics),
        .in_lab       (in_lab),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_total    (out_total),
        .out_avg      (out_avg),
        .out_grade    (out_grade),
        .out_fail     (out_fail)
`ifdef COLLEGE_REPORT_STATS_EN
        ,
        .stat_count   (stat_count),
        .stat_max_avg (stat_max_avg)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one record at the falling edge; it is taken on the next rising edge.
    task automatic push_rec(input logic [7:0] m, input logic [7:0] p, input logic [7:0] l);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout_in_ready", int'(in_ready), 1);
        end
        in_valid   = 1'b1;
        in_math    = m;
        in_physics = p;
        in_lab     = l;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    // Wait (bounded) until out_valid, sampling 1 time unit after each rising edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_seen", int'(out_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int stale;

        vecs[0]  = '{8'd85,  8'd90,  8'd95,  270, 90,  0, 0};
        vecs[1]  = '{8'd85,  8'd90,  8'd99,  274, 91,  0, 0};
        vecs[2]  = '{8'd0,   8'd0,   8'd0,   0,   0,   4, 1};
        vecs[3]  = '{8'd255, 8'd255, 8'd255, 765, 255, 0, 0};
        vecs[4]  = '{8'd90,  8'd90,  8'd30,  210, 70,  2, 1};
        vecs[5]  = '{8'd80,  8'd80,  8'd79,  239, 79,  2, 0};
        vecs[6]  = '{8'd60,  8'd60,  8'd60,  180, 60,  3, 0};
        vecs[7]  = '{8'd59,  8'd60,  8'd60,  179, 59,  4, 0};
        vecs[8]  = '{8'd40,  8'd40,  8'd39,  119, 39,  4, 1};
        vecs[9]  = '{8'd80,  8'd80,  8'd80,  240, 80,  1, 0};
        vecs[10] = '{8'd100, 8'd100, 8'd100, 300, 100, 0, 0};

        bp[0] = '{8'd10,  8'd20, 8'd30, 60,  20, 4, 1};
        bp[1] = '{8'd50,  8'd50, 8'd50, 150, 50, 4, 0};
        bp[2] = '{8'd70,  8'd80, 8'd90, 240, 80, 1, 0};
        bp[3] = '{8'd100, 8'd90, 8'd95, 285, 95, 0, 0};
        bp[4] = '{8'd1,   8'd2,  8'd3,  6,   2,  4, 1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_math    = 8'd0;
        in_physics = 8'd0;
        in_lab     = 8'd0;
        out_ready  = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_total", int'(out_total), 0);
        check("rst_out_avg",   int'(out_avg),   0);
        check("rst_out_fail",  int'(out_fail),  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single records into an idle block, consumer always ready
        for (int i = 0; i < 11; i++) begin
            push_rec(vecs[i].m, vecs[i].p, vecs[i].l);
            wait_valid(lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_total", i), int'(out_total), vecs[i].total);
            check($sformatf("v%0d_avg", i),   int'(out_avg),   vecs[i].avg);
            check($sformatf("v%0d_grade", i), int'(out_grade), vecs[i].grade);
            check($sformatf("v%0d_fail", i),  int'(out_fail),  vecs[i].fail);
            @(posedge clk);
            #1;
            hs_count++;
            if (vecs[i].avg > max_avg_model) max_avg_model = vecs[i].avg;
            check($sformatf("v%0d_valid_drop", i), int'(out_valid), 0);
        end

        // Backpressure: five records with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_rec(bp[i].m, bp[i].p, bp[i].l);
        end
        check("bp_in_ready_full", int'(in_ready), 0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_hold_valid",    int'(out_valid), 1);
        check("bp_hold_total",    int'(out_total), bp[0].total);
        check("bp_still_full",    int'(in_ready),  0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(lat);
            check($sformatf("bp%0d_total", i), int'(out_total), bp[i].total);
            check($sformatf("bp%0d_avg", i),   int'(out_avg),   bp[i].avg);
            check($sformatf("bp%0d_grade", i), int'(out_grade), bp[i].grade);
            check($sformatf("bp%0d_fail", i),  int'(out_fail),  bp[i].fail);
            @(posedge clk);
            #1;
            hs_count++;
            if (bp[i].avg > max_avg_model) max_avg_model = bp[i].avg;
        end
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_extra_report", int'(out_valid), 0);
        check("bp_in_ready_back",   int'(in_ready),  1);

`ifdef COLLEGE_REPORT_STATS_EN
        check("stat_count",   int'(stat_count),   hs_count);
        check("stat_max_avg", int'(stat_max_avg), max_avg_model);
        check("stat_max_255", int'(stat_max_avg), 255);
`endif

        // Reset while holding a report with two more queued
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_rec(bp[i].m, bp[i].p, bp[i].l);
        end
        wait_valid(lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready",  int'(in_ready),  1);
        check("mid_rst_out_total", int'(out_total), 0);
        check("mid_rst_out_avg",   int'(out_avg),   0);
`ifdef COLLEGE_REPORT_STATS_EN
        check("mid_rst_stat_count", int'(stat_count), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("post_rst_no_stale", stale, 0);

        // Block is fully usable after reset
        push_rec(vecs[0].m, vecs[0].p, vecs[0].l);
        wait_valid(lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_total",   int'(out_total), vecs[0].total);
        check("post_rst_grade",   int'(out_grade), vecs[0].grade);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
